// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared definitions for the I2C bus arbiter: bus field widths, the ADV7513
// device address and the arbiter FSM state encoding.
package i2c_bus_arbiter_pkg;

    localparam int I2C_ADDR_W = 8;
    localparam int I2C_DATA_W = 16;

    // ADV7513 HDMI transmitter, 8-bit write address
    localparam logic [I2C_ADDR_W-1:0] ADV7513_ADDR = 8'h72;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_REPORT
    } arb_state_e;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Bundle between the init sequencers / i2c_controller and the arbiter.
//   req, req_dev_addr, req_reg_data : requester side, per-requester slices
//   grant, done, nack, timeout      : per-requester status back to requesters
//   i2c_start/dev_addr/reg_data     : command to i2c_controller
//   i2c_ready, i2c_ack              : status from i2c_controller
//   busy                            : arbiter not idle
// master = arbiter view, slave = requesters + controller view.
interface i2c_bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import i2c_bus_arbiter_pkg::*;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*I2C_ADDR_W-1:0] req_dev_addr;
    logic [NUM_REQ*I2C_DATA_W-1:0] req_reg_data;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            nack;
    logic [NUM_REQ-1:0]            timeout;
    logic                          i2c_start;
    logic [I2C_ADDR_W-1:0]         i2c_dev_addr;
    logic [I2C_DATA_W-1:0]         i2c_reg_data;
    logic                          i2c_ready;
    logic                          i2c_ack;
    logic                          busy;

    modport master (
        input  req, req_dev_addr, req_reg_data, i2c_ready, i2c_ack,
        output grant, done, nack, timeout, i2c_start, i2c_dev_addr, i2c_reg_data, busy
    );

    modport slave (
        output req, req_dev_addr, req_reg_data, i2c_ready, i2c_ack,
        input  grant, done, nack, timeout, i2c_start, i2c_dev_addr, i2c_reg_data, busy
    );

endinterface

// File: rtl/i2c_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req    : pending request bits
//   rr_ptr : highest-priority index for this pick
//   sel    : first requester at or after rr_ptr (modulo NUM_REQ)
//   valid  : at least one request pending
module i2c_bus_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   sel,
    output logic               valid
);

    // Walk the priority order backwards so the last hit, i.e. the one
    // closest to rr_ptr, is what remains in sel.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                sel   = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one i2c_controller between NUM_REQ register-write requesters.
// Round-robin grant, latches the winner's address/data, pulses start for
// START_HOLD cycles, follows ready low->high and reports done/nack/timeout.
//   clk_in    : divided I2C state clock
//   reset_not : synchronous active-low reset
//   bus       : requester and controller signals (master modport)
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = 64
) (
    input logic               clk_in,
    input logic               reset_not,
    i2c_bus_arbiter_if.master bus
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = $clog2(START_HOLD + 1);

    arb_state_e              state, state_n;
    logic [NUM_REQ-1:0]      grant, grant_n, done, done_n;
    logic [NUM_REQ-1:0]      nack, nack_n, tmo, tmo_n;
    logic                    start, start_n;
    logic [I2C_ADDR_W-1:0]   dev, dev_n;
    logic [I2C_DATA_W-1:0]   data, data_n;
    logic [PTR_W-1:0]        cur, cur_n, rr_ptr, rr_ptr_n;
    logic [HOLD_W-1:0]       hold, hold_n;
    logic [7:0]              to_cnt, to_cnt_n;
    logic [PTR_W-1:0]        pick;
    logic                    pick_vld;

    i2c_bus_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .sel    (pick),
        .valid  (pick_vld)
    );

    always_ff @(posedge clk_in) begin
        if (!reset_not) begin
            state  <= ST_IDLE;
            grant  <= '0;
            done   <= '0;
            nack   <= '0;
            tmo    <= '0;
            start  <= 1'b0;
            dev    <= '0;
            data   <= '0;
            cur    <= '0;
            rr_ptr <= '0;
            hold   <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            done   <= done_n;
            nack   <= nack_n;
            tmo    <= tmo_n;
            start  <= start_n;
            dev    <= dev_n;
            data   <= data_n;
            cur    <= cur_n;
            rr_ptr <= rr_ptr_n;
            hold   <= hold_n;
            to_cnt <= to_cnt_n;
        end
    end

    // Next-state logic. All outputs are registered, so status pulses are
    // raised on the transition into REPORT and cleared on the way out.
    always_comb begin
        state_n  = state;
        grant_n  = grant;
        done_n   = '0;
        nack_n   = '0;
        tmo_n    = '0;
        start_n  = 1'b0;
        dev_n    = dev;
        data_n   = data;
        cur_n    = cur;
        rr_ptr_n = rr_ptr;
        hold_n   = hold;
        to_cnt_n = to_cnt;

        case (state)
            ST_IDLE: begin
                if (pick_vld && bus.i2c_ready) begin
                    state_n        = ST_ISSUE;
                    grant_n        = '0;
                    grant_n[pick]  = 1'b1;
                    cur_n          = pick;
                    dev_n          = bus.req_dev_addr[int'(pick)*I2C_ADDR_W +: I2C_ADDR_W];
                    data_n         = bus.req_reg_data[int'(pick)*I2C_DATA_W +: I2C_DATA_W];
                    hold_n         = '0;
                    to_cnt_n       = '0;
                end
            end

            ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE: begin
                to_cnt_n = to_cnt + 8'd1;
                // A hung controller wins over a ready edge in the same cycle.
                if (to_cnt == 8'(TIMEOUT)) begin
                    state_n    = ST_REPORT;
                    done_n[cur] = 1'b1;
                    tmo_n[cur]  = 1'b1;
                end else begin
                    case (state)
                        ST_ISSUE: begin
                            // First ISSUE cycle only arms start; it is then
                            // high for exactly START_HOLD cycles.
                            if (hold < HOLD_W'(START_HOLD)) begin
                                start_n = 1'b1;
                                hold_n  = hold + HOLD_W'(1);
                            end else begin
                                state_n = ST_WAIT_BUSY;
                            end
                        end
                        ST_WAIT_BUSY: begin
                            if (!bus.i2c_ready) state_n = ST_WAIT_DONE;
                        end
                        default: begin
                            if (bus.i2c_ready) begin
                                state_n     = ST_REPORT;
                                done_n[cur] = 1'b1;
                                nack_n[cur] = !bus.i2c_ack;
                            end
                        end
                    endcase
                end
            end

            ST_REPORT: begin
                state_n = ST_IDLE;
                grant_n = '0;
                if (int'(cur) == NUM_REQ - 1) rr_ptr_n = '0;
                else                          rr_ptr_n = cur + PTR_W'(1);
            end

            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.grant        = grant;
    assign bus.done         = done;
    assign bus.nack         = nack;
    assign bus.timeout      = tmo;
    assign bus.i2c_start    = start;
    assign bus.i2c_dev_addr = dev;
    assign bus.i2c_reg_data = data;
    assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;
    import i2c_bus_arbiter_pkg::*;

    localparam int N = 2;
    localparam int START_HOLD = 2;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_bus_arbiter_if #(.NUM_REQ(N)) bus();

    i2c_bus_arbiter #(.NUM_REQ(N), .START_HOLD(START_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk_in    (clk),
        .reset_not (rst_n),
        .bus       (bus)
    );

    // controller model knobs (written by the main sequence)
    int   ctl_len  = 20;
    logic ctl_ack  = 1'b1;
    logic ctl_hang = 1'b0;
    int   ctl_kick = 0;
    logic ready_en = 1'b0;
    // controller model state (written only by the model)
    logic ctl_ready;
    logic ctl_ack_o;

    assign bus.i2c_ready = ctl_ready & ready_en;
    assign bus.i2c_ack   = ctl_ack_o;

    // i2c_controller model: goes busy one cycle after it sees start, stays
    // busy ctl_len cycles, then returns ready with the chosen ack.
    initial begin
        int phase, cnt, kick_seen;
        ctl_ready = 1'b1; ctl_ack_o = 1'b0;
        phase = 0; cnt = 0; kick_seen = 0;
        forever begin
            @(posedge clk); #1;
            if (ctl_kick != kick_seen) begin
                kick_seen = ctl_kick; phase = 0; ctl_ready = 1'b1;
            end else begin
                case (phase)
                    0: if (bus.i2c_start) phase = 1;
                    1: begin ctl_ready = 1'b0; cnt = ctl_len; phase = 2; end
                    2: if (!ctl_hang) begin
                        cnt--;
                        if (cnt == 0) begin ctl_ready = 1'b1; ctl_ack_o = ctl_ack; phase = 3; end
                    end
                    default: if (!bus.i2c_start) phase = 0;
                endcase
            end
        end
    end

    int checks = 0, errors = 0;
    int cyc = 0, start_first = 0, start_run = 0, last_run = 0;
    int rise_cyc = 0, grant_cyc = 0, done_cyc = 0;
    logic start_prev = 1'b0, ready_prev = 1'b0;
    logic [N-1:0] grant_prev = '0;
    logic [N-1:0] req_v = '0;
    logic [7:0]  dev_v  [N];
    logic [15:0] data_v [N];
    int ref_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic drive();
        bus.req = req_v;
        for (int i = 0; i < N; i++) begin
            bus.req_dev_addr[8*i +: 8]   = dev_v[i];
            bus.req_reg_data[16*i +: 16] = data_v[i];
        end
    endtask

    // advance one cycle, sample 2 time units after the edge, track events
    task automatic step();
        @(posedge clk); #2;
        cyc++;
        if (bus.i2c_start && !start_prev) start_first = cyc;
        if (bus.i2c_start) start_run++;
        else if (start_prev) begin last_run = start_run; start_run = 0; end
        if (bus.i2c_ready && !ready_prev) rise_cyc = cyc;
        if (bus.grant != 0 && grant_prev == 0) grant_cyc = cyc;
        if (bus.done != 0) done_cyc = cyc;
        chk("grant_onehot", 32'($countones(bus.grant) <= 1), 1);
        chk("busy_vs_grant", 32'(bus.busy), 32'(bus.grant != 0));
        chk("flags_only_with_done", 32'((bus.nack | bus.timeout) & ~bus.done), 0);
        start_prev = bus.i2c_start; ready_prev = bus.i2c_ready; grant_prev = bus.grant;
    endtask

    // reference pick: first pending requester at or after ptr
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // mode 0: drop req at done, 1: keep req (new request), 2: drop right after grant
    task automatic run_txn(input int idx, input logic exp_nack, input logic exp_to, input int mode);
        int n;
        logic [7:0] sdev; logic [15:0] sdata;
        logic [31:0] bit_i;
        bit_i = 32'd1 << idx;
        n = 0;
        while (bus.grant == 0 && n < 40) begin step(); n++; end
        chk("grant_wait", 32'(bus.grant != 0), 1);
        chk("grant_idx", 32'(bus.grant), bit_i);
        chk("dev_latched", 32'(bus.i2c_dev_addr), 32'(dev_v[idx]));
        chk("data_latched", 32'(bus.i2c_reg_data), 32'(data_v[idx]));
        sdev = dev_v[idx]; sdata = data_v[idx];
        // requester side moves on; the latched command must not follow
        dev_v[idx] = 8'($urandom); data_v[idx] = 16'($urandom);
        if (mode == 2) req_v[idx] = 1'b0;
        drive();
        n = 0;
        while (bus.done == 0 && n < 200) begin step(); n++; end
        chk("done_wait", 32'(bus.done != 0), 1);
        chk("done_idx", 32'(bus.done), bit_i);
        chk("nack", 32'(bus.nack), exp_nack ? bit_i : 0);
        chk("timeout", 32'(bus.timeout), exp_to ? bit_i : 0);
        chk("grant_at_done", 32'(bus.grant), bit_i);
        chk("dev_stable", 32'(bus.i2c_dev_addr), 32'(sdev));
        chk("data_stable", 32'(bus.i2c_reg_data), 32'(sdata));
        chk("start_len", 32'(last_run), START_HOLD);
        chk("start_after_grant", 32'(start_first - grant_cyc), 1);
        if (exp_to) chk("timeout_cycle", 32'(done_cyc - start_first), TIMEOUT);
        else        chk("done_after_ready", 32'(done_cyc - rise_cyc), 1);
        ref_ptr = (idx + 1) % N;
        if (mode == 0) req_v[idx] = 1'b0;
        drive();
        step();
        chk("done_pulse", 32'(bus.done), 0);
        chk("grant_drop", 32'(bus.grant), 0);
        chk("busy_fall", 32'(bus.busy), 0);
    endtask

    initial begin
        int n, e, mode;
        logic saw;
        bus.req = '0; bus.req_dev_addr = '0; bus.req_reg_data = '0;
        for (int i = 0; i < N; i++) begin dev_v[i] = 8'h10 + 8'(i); data_v[i] = 16'h1000 + 16'(i); end

        // reset with a pending request and the controller not ready
        dev_v[0] = ADV7513_ADDR; data_v[0] = 16'h9803; req_v = 2'b01; drive();
        step(); step();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_nack", 32'(bus.nack), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        chk("rst_start", 32'(bus.i2c_start), 0);
        chk("rst_dev", 32'(bus.i2c_dev_addr), 0);
        chk("rst_data", 32'(bus.i2c_reg_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("no_grant_not_ready", 32'(bus.grant), 0);
        ready_en = 1'b1;
        step();
        chk("grant_after_ready", 32'(bus.grant), 32'b01);

        // single request to the HDMI transmitter
        ctl_len = 20; ctl_ack = 1'b1;
        run_txn(0, 1'b0, 1'b0, 0);

        // contention: both requesters keep requesting
        req_v = 2'b11; drive();
        for (int t = 0; t < 4; t++) begin
            ctl_len = 5 + t; ctl_ack = 1'b1;
            e = pick(req_v, ref_ptr);
            run_txn(e, 1'b0, 1'b0, 1);
        end

        // NACK followed by a normal transaction
        ctl_len = 8; ctl_ack = 1'b0;
        e = pick(req_v, ref_ptr);
        run_txn(e, 1'b1, 1'b0, 0);
        ctl_ack = 1'b1;
        e = pick(req_v, ref_ptr);
        run_txn(e, 1'b0, 1'b0, 0);
        req_v = '0; drive();

        // randomized request patterns, busy times, acks and req behaviour
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < N; i++)
                if (!req_v[i] && $urandom_range(0, 1) == 1) begin
                    req_v[i] = 1'b1; dev_v[i] = 8'($urandom); data_v[i] = 16'($urandom);
                end
            if (req_v == 0) req_v[$urandom_range(0, N - 1)] = 1'b1;
            drive();
            ctl_len = $urandom_range(3, 25);
            ctl_ack = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            e = pick(req_v, ref_ptr);
            run_txn(e, !ctl_ack, 1'b0, mode);
        end
        req_v = '0; drive();
        step();

        // hung controller
        req_v = 2'b01; drive();
        ctl_hang = 1'b1; ctl_ack = 1'b0;
        run_txn(pick(req_v, ref_ptr), 1'b0, 1'b1, 0);
        ctl_hang = 1'b0; ctl_kick++;
        step(); step();

        // reset in the middle of WAIT_DONE; make rr_ptr point at 1 first
        ctl_ack = 1'b1; ctl_len = 6;
        req_v = 2'b01; drive();
        run_txn(0, 1'b0, 1'b0, 0);
        req_v = 2'b10; drive();
        ctl_len = 30;
        n = 0;
        while (bus.grant == 0 && n < 40) begin step(); n++; end
        chk("abort_grant", 32'(bus.grant), 32'b10);
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0; req_v = '0; drive();
        step();
        rst_n = 1'b1;
        chk("abort_grant_clr", 32'(bus.grant), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_start", 32'(bus.i2c_start), 0);
        chk("abort_dev", 32'(bus.i2c_dev_addr), 0);
        chk("abort_data", 32'(bus.i2c_reg_data), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin step(); saw = saw | (bus.done != 0); end
        chk("abort_no_done", 32'(saw), 0);
        ref_ptr = 0;
        ctl_len = 7;
        req_v = 2'b11; drive();
        e = pick(req_v, ref_ptr);
        chk("after_reset_pick0", 32'(e), 0);
        run_txn(e, 1'b0, 1'b0, 0);
        run_txn(pick(req_v, ref_ptr), 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
